// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants and the carry helper for the full_adder slice.
//   FA_DEFAULT_WIDTH : operand width used when no WIDTH override is given
//   FA_MAX_WIDTH     : widest operand the ripple chain is intended for
//   fa_majority()    : 2-of-3 majority, i.e. the full-adder carry equation
// -----------------------------------------------------------------------------
package full_adder_pkg;

   localparam int FA_DEFAULT_WIDTH = 1;
   localparam int FA_MAX_WIDTH     = 64;

   // Plain gate form (no case/if) so an X on any input reaches the result
   // unless the other two inputs already decide it.
   function automatic logic fa_majority(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/full_adder_if.sv
// -----------------------------------------------------------------------------
// full_adder_if
// Bundles the operand / result signals of full_adder.
//   a, b      : WIDTH-bit unsigned operands
//   ci        : carry into bit 0
//   in_valid  : qualifies a/b/ci for capture into the register stage
//   s, co     : combinational sum and carry-out
//   s_q, co_q : registered sum and carry-out
//   out_valid : s_q/co_q hold a result captured from a valid input
//   ovf, ovf_q: signed overflow, combinational and registered
//               (present only when FULL_ADDER_OVF_EN is defined)
// Modports: master drives operands, slave is the adder.
// -----------------------------------------------------------------------------
interface full_adder_if
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) ();

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             in_valid;
   logic [WIDTH-1:0] s;
   logic             co;
   logic [WIDTH-1:0] s_q;
   logic             co_q;
   logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
   logic             ovf;
   logic             ovf_q;

   modport master (
      output a, b, ci, in_valid,
      input  s, co, s_q, co_q, out_valid, ovf, ovf_q
   );

   modport slave (
      input  a, b, ci, in_valid,
      output s, co, s_q, co_q, out_valid, ovf, ovf_q
   );
`else
   modport master (
      output a, b, ci, in_valid,
      input  s, co, s_q, co_q, out_valid
   );

   modport slave (
      input  a, b, ci, in_valid,
      output s, co, s_q, co_q, out_valid
   );
`endif

endinterface

// File: rtl/full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// One purely combinational full-adder cell.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit  = a ^ b ^ ci
//   co   : carry out = majority(a, b, ci)
// -----------------------------------------------------------------------------
module full_adder_bit
   import full_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = fa_majority(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// WIDTH-bit ripple-carry adder built from full_adder_bit cells, with an
// optional-use output register stage qualified by in_valid.
//   clk   : rising-edge clock for the register stage
//   rst_n : asynchronous active-low reset of the register stage only
//   bus   : full_adder_if.slave (a, b, ci, in_valid in; s, co, s_q, co_q,
//           out_valid out). WIDTH must match the interface's WIDTH.
// Legal WIDTH range is 1..FA_MAX_WIDTH.
// Optional macro FULL_ADDER_OVF_EN adds ovf / ovf_q (two's-complement
// signed overflow, combinational and registered).
// -----------------------------------------------------------------------------
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   full_adder_if.slave  bus
);

   // c[i] is the carry into bit i; c[0] is the external carry-in and
   // c[WIDTH] the carry out of the MSB.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s_comb;

   logic [WIDTH-1:0] s_reg;
   logic             co_reg;
   logic             valid_reg;

   assign c[0] = bus.ci;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_bit (
         .a  (bus.a[i]),
         .b  (bus.b[i]),
         .ci (c[i]),
         .s  (s_comb[i]),
         .co (c[i+1])
      );
   end

   // Combinational results never look at clk or rst_n.
   assign bus.s  = s_comb;
   assign bus.co = c[WIDTH];

`ifdef FULL_ADDER_OVF_EN
   logic ovf_comb;
   logic ovf_reg;

   // Signed overflow: carry into the sign bit differs from carry out of it.
   // For WIDTH=1 the carry into the sign bit is ci itself.
   assign ovf_comb  = c[WIDTH] ^ c[WIDTH-1];
   assign bus.ovf   = ovf_comb;
   assign bus.ovf_q = ovf_reg;
`endif

   // Result register: a valid input is captured, an idle cycle keeps the
   // old data but drops out_valid. Reset clears everything immediately,
   // which also throws away whatever was about to be captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg     <= '0;
         co_reg    <= 1'b0;
         valid_reg <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
         ovf_reg   <= 1'b0;
`endif
      end else if (bus.in_valid) begin
         s_reg     <= s_comb;
         co_reg    <= c[WIDTH];
         valid_reg <= 1'b1;
`ifdef FULL_ADDER_OVF_EN
         ovf_reg   <= ovf_comb;
`endif
      end else begin
         valid_reg <= 1'b0;
      end
   end

   assign bus.s_q       = s_reg;
   assign bus.co_q      = co_reg;
   assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Self-checking bench for full_adder: a WIDTH=1 instance for the basic cell
// truth table and a WIDTH=4 instance for the sweep, carry-ripple corners,
// the register stage and asynchronous reset. Checks ovf/ovf_q when
// FULL_ADDER_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_full_adder;

   logic clk;
   logic rst_n;

   int check_count;
   int pass_count;

   full_adder_if #(.WIDTH(1)) bus1 ();
   full_adder_if #(.WIDTH(4)) bus4 ();

   full_adder #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   full_adder #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic a;
      logic b;
      logic ci;
      logic s;
      logic co;
   } bit_vec_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      logic [3:0] s;
      logic       co;
      logic       ovf;
   } nib_vec_t;

   bit_vec_t bit_table [8];
   nib_vec_t nib_table [6];

   // Single place where pass/fail is decided and counted.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulusBit(input logic a, input logic b, input logic ci);
      bus1.a        = a;
      bus1.b        = b;
      bus1.ci       = ci;
      bus1.in_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                input logic ci, input logic in_valid);
      bus4.a        = a;
      bus4.b        = b;
      bus4.ci       = ci;
      bus4.in_valid = in_valid;
   endtask

   initial begin
      logic [8:0] sweep;
      logic [4:0] expected_sum;

      check_count = 0;
      pass_count  = 0;

      // Hand-computed truth table of the 1-bit cell.
      bit_table[0] = '{a:1'b0, b:1'b0, ci:1'b0, s:1'b0, co:1'b0};
      bit_table[1] = '{a:1'b0, b:1'b0, ci:1'b1, s:1'b1, co:1'b0};
      bit_table[2] = '{a:1'b0, b:1'b1, ci:1'b0, s:1'b1, co:1'b0};
      bit_table[3] = '{a:1'b0, b:1'b1, ci:1'b1, s:1'b0, co:1'b1};
      bit_table[4] = '{a:1'b1, b:1'b0, ci:1'b0, s:1'b1, co:1'b0};
      bit_table[5] = '{a:1'b1, b:1'b0, ci:1'b1, s:1'b0, co:1'b1};
      bit_table[6] = '{a:1'b1, b:1'b1, ci:1'b0, s:1'b0, co:1'b1};
      bit_table[7] = '{a:1'b1, b:1'b1, ci:1'b1, s:1'b1, co:1'b1};

      // 4-bit corners, including the signed-overflow cases.
      nib_table[0] = '{a:4'd15, b:4'd15, ci:1'b1, s:4'd15, co:1'b1, ovf:1'b0};
      nib_table[1] = '{a:4'd15, b:4'd0,  ci:1'b1, s:4'd0,  co:1'b1, ovf:1'b0};
      nib_table[2] = '{a:4'd0,  b:4'd0,  ci:1'b0, s:4'd0,  co:1'b0, ovf:1'b0};
      nib_table[3] = '{a:4'd7,  b:4'd1,  ci:1'b0, s:4'd8,  co:1'b0, ovf:1'b1};
      nib_table[4] = '{a:4'd8,  b:4'd8,  ci:1'b0, s:4'd0,  co:1'b1, ovf:1'b1};
      nib_table[5] = '{a:4'd3,  b:4'd2,  ci:1'b0, s:4'd5,  co:1'b0, ovf:1'b0};

      rst_n = 1'b0;
      applyStimulusBit(1'b0, 1'b0, 1'b0);
      applyStimulus(4'd0, 4'd0, 1'b0, 1'b0);

      #2;
      checkOutput("reset s_q", 64'(bus4.s_q), 64'd0);
      checkOutput("reset co_q", 64'(bus4.co_q), 64'd0);
      checkOutput("reset out_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("reset out_valid w1", 64'(bus1.out_valid), 64'd0);
`ifdef FULL_ADDER_OVF_EN
      checkOutput("reset ovf_q", 64'(bus4.ovf_q), 64'd0);
`endif

      // 1-bit cell, one vector every 20 time units.
      for (int i = 0; i < 8; i++) begin
         applyStimulusBit(bit_table[i].a, bit_table[i].b, bit_table[i].ci);
         #1;
         checkOutput($sformatf("w1 s vec%0d", i), 64'(bus1.s), 64'(bit_table[i].s));
         checkOutput($sformatf("w1 co vec%0d", i), 64'(bus1.co), 64'(bit_table[i].co));
`ifdef FULL_ADDER_OVF_EN
         checkOutput($sformatf("w1 ovf vec%0d", i), 64'(bus1.ovf),
                     64'(bit_table[i].ci ^ bit_table[i].co));
`endif
         #19;
      end

      // Exhaustive 4-bit sweep of {a,b,ci}; still in reset, which must not
      // disturb the combinational path.
      for (int i = 0; i < 512; i++) begin
         sweep = 9'(i);
         applyStimulus(sweep[8:5], sweep[4:1], sweep[0], 1'b0);
         expected_sum = 5'(sweep[8:5]) + 5'(sweep[4:1]) + 5'(sweep[0]);
         #1;
         checkOutput($sformatf("sweep %0d", i), 64'({bus4.co, bus4.s}),
                     64'(expected_sum));
      end

      for (int i = 0; i < 6; i++) begin
         applyStimulus(nib_table[i].a, nib_table[i].b, nib_table[i].ci, 1'b0);
         #1;
         checkOutput($sformatf("w4 s vec%0d", i), 64'(bus4.s), 64'(nib_table[i].s));
         checkOutput($sformatf("w4 co vec%0d", i), 64'(bus4.co), 64'(nib_table[i].co));
`ifdef FULL_ADDER_OVF_EN
         checkOutput($sformatf("w4 ovf vec%0d", i), 64'(bus4.ovf), 64'(nib_table[i].ovf));
`endif
      end

      // Release reset between edges.
      @(negedge clk);
      rst_n = 1'b1;

      // 9+8+0 = 17 -> s_q=1, co_q=1 right after the capturing edge.
      @(negedge clk);
      applyStimulus(4'd9, 4'd8, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("cap s_q", 64'(bus4.s_q), 64'd1);
      checkOutput("cap co_q", 64'(bus4.co_q), 64'd1);
      checkOutput("cap out_valid", 64'(bus4.out_valid), 64'd1);

      // Idle cycle: data holds, valid drops.
      applyStimulus(4'd2, 4'd3, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("idle out_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("idle s_q hold", 64'(bus4.s_q), 64'd1);
      checkOutput("idle co_q hold", 64'(bus4.co_q), 64'd1);

      // 5+6+1 = 12 captured, then reset hits mid-cycle.
      applyStimulus(4'd5, 4'd6, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("cap2 s_q", 64'(bus4.s_q), 64'd12);
      checkOutput("cap2 co_q", 64'(bus4.co_q), 64'd0);
      checkOutput("cap2 out_valid", 64'(bus4.out_valid), 64'd1);

      applyStimulus(4'd15, 4'd15, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async rst s_q", 64'(bus4.s_q), 64'd0);
      checkOutput("async rst co_q", 64'(bus4.co_q), 64'd0);
      checkOutput("async rst out_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("rst comb s", 64'(bus4.s), 64'd15);
      checkOutput("rst comb co", 64'(bus4.co), 64'd1);
      applyStimulus(4'd15, 4'd0, 1'b1, 1'b1);
      #1;
      checkOutput("rst comb ripple s", 64'(bus4.s), 64'd0);
      checkOutput("rst comb ripple co", 64'(bus4.co), 64'd1);

      // Edge while held in reset: pending input is discarded.
      @(posedge clk);
      #1;
      checkOutput("held rst out_valid", 64'(bus4.out_valid), 64'd0);
      checkOutput("held rst s_q", 64'(bus4.s_q), 64'd0);

      // First edge after release captures 15+0+1 = 16.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post rst out_valid", 64'(bus4.out_valid), 64'd1);
      checkOutput("post rst s_q", 64'(bus4.s_q), 64'd0);
      checkOutput("post rst co_q", 64'(bus4.co_q), 64'd1);

`ifdef FULL_ADDER_OVF_EN
      // ovf_q follows ovf one cycle later and holds while idle.
      applyStimulus(4'd7, 4'd1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("ovf_q set", 64'(bus4.ovf_q), 64'd1);
      checkOutput("ovf_q s_q", 64'(bus4.s_q), 64'd8);
      applyStimulus(4'd3, 4'd2, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("ovf_q clear", 64'(bus4.ovf_q), 64'd0);
      applyStimulus(4'd8, 4'd8, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("ovf_q hold", 64'(bus4.ovf_q), 64'd0);
      checkOutput("ovf_q idle valid", 64'(bus4.out_valid), 64'd0);
`endif

      applyStimulus(4'd0, 4'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("final out_valid", 64'(bus4.out_valid), 64'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Bit-level binary adder: sum = a XOR b XOR ci, carry-out = majority(a, b, ci).
- Parameterised to WIDTH bits as a ripple chain of 1-bit cells. Default WIDTH=1 is the plain 1-bit full adder cell.
- Combinational results are always available. An optional-use registered copy with a valid flag feeds pipelined datapaths such as multi-bit adders and ALUs.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the output register stage
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- ci  input  1  carry-in to bit 0
- in_valid  input  1  qualifies a/b/ci for capture into the register stage
- s  output  WIDTH  combinational sum
- co  output  1  combinational carry-out of the MSB
- s_q  output  WIDTH  registered sum
- co_q  output  1  registered carry-out
- out_valid  output  1  s_q/co_q hold a result captured from a valid input

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Per bit i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = ci; co = c[WIDTH]
- Arithmetic: {co, s} == a + b + ci exactly, modulo 2^(WIDTH+1). No saturation.
- s and co are purely combinational, zero latency, and independent of clk and rst_n, including during reset.
- Register stage:
  - On a rising clk edge with in_valid=1: s_q<=s, co_q<=co, out_valid<=1.
  - On an edge with in_valid=0: s_q and co_q hold; out_valid<=0.
  - Latency is 1 cycle from a valid input to out_valid.
- Reset:
  - rst_n=0 forces s_q=0, co_q=0, out_valid=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards the pending result.
  - Release is synchronised by the first clk edge after deassertion; the first capture happens at that edge if in_valid=1.
- Boundary cases:
  - All-ones operands with ci=1 give s=all-ones, co=1.
  - All-zero inputs give s=0, co=0.
  - Carry ripples fully through WIDTH bits (e.g. a=all-ones, b=0, ci=1 gives s=0, co=1).
- X-propagation: no defaults are substituted; X inputs propagate to s and co.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- When defined, adds:
  - output ovf (1 bit) = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed overflow (for WIDTH=1: ci ^ co).
  - output ovf_q, registered with the same rules as co_q; reset value 0.
- When undefined, neither port exists and no related logic is generated.

Decomposition:
- Package full_adder_pkg:
  - localparam FA_DEFAULT_WIDTH = 1
  - localparam FA_MAX_WIDTH = 64
  - function fa_majority(a, b, c) for the carry equation
- Sub-module full_adder_bit: 1-bit cell with inputs a, b, ci and outputs s, co, purely combinational.
  - full_adder instantiates WIDTH copies in a generate loop, chained through the internal carry vector c[WIDTH:0].
  - The register stage lives in the top module.

Test Plan:
- WIDTH=1, all 8 {a,b,ci} combinations, applied combinationally 20 time units apart:
  - 000 -> s=0, co=0
  - 011 -> s=0, co=1
  - 100 -> s=1, co=0
  - 111 -> s=1, co=1
- WIDTH=4, exhaustive 512-step counting sweep of {a,b,ci} from 0 to 511 -> {co,s} == a+b+ci at every step. Spot checks:
  - a=15, b=15, ci=1 -> s=15, co=1
  - a=15, b=0, ci=1 -> s=0, co=1
- Registered path, WIDTH=4:
  - a=9, b=8, ci=0, in_valid=1 at edge N -> at N: s_q=1, co_q=1, out_valid=1.
  - in_valid=0 at edge N+1 -> out_valid=0, s_q still 1.
- Asynchronous reset:
  - rst_n low between clock edges while out_valid=1 -> s_q=0, co_q=0, out_valid=0 before the next edge.
  - Meanwhile s and co continue to track inputs.
- FULL_ADDER_OVF_EN, WIDTH=4:
  - a=7, b=1, ci=0 -> s=8, ovf=1
  - a=8, b=8, ci=0 -> s=0, co=1, ovf=1
  - a=3, b=2, ci=0 -> ovf=0
  - ovf_q follows one cycle later under in_valid.
